data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory interface; serves the memory-stage load/store requests the core issues.
- Requests carry a byte address, a 4-bit byte write-enable, pre-replicated write data and a request strobe.
- Block holds a word-organised RAM, applies programmable wait states, and returns the full 32-bit read word plus a stall that freezes the pipeline while busy.
- Byte and halfword lane extraction and sign extension stay in the core.

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the core and the responder.
// master = core side, slave = memory responder side.
interface data_mem_responder_if;
  logic        req_en;
  logic [3:0]  req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall;
  logic        err;

  modport master (
    output req_en, req_wen, req_addr, req_wdata,
    input  rdata, rvalid, stall, err
  );

  modport slave (
    input  req_en, req_wen, req_addr, req_wdata,
    output rdata, rvalid, stall, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM with programmable wait states and a pipeline stall.
// Optional macro ALIGN_CHECK_EN: flags and suppresses misaligned writes.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [31:0] mem [DEPTH];

  logic [3:0]            cnt;
  logic [ADDR_WIDTH+1:0] addrQ;
  logic [3:0]            wenQ;
  logic [31:0]           wdataQ;

  logic [ADDR_WIDTH+1:0] addrSel;
  logic [3:0]            wenSel;
  logic [31:0]           wdataSel;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            wenEff;
  logic [31:0]           oldWord;
  logic [31:0]           newWord;

  logic accept;
  logic enterDone;
  logic misaligned;
  logic stall;
  logic [31:0] rdataQ;
  logic rvalidQ;

  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.req_addr[31:ADDR_WIDTH+2];

  // With zero wait states the access completes straight from IDLE,
  // so the live request is used there and the latched copy elsewhere.
  always_comb begin
    addrSel  = addrQ;
    wenSel   = wenQ;
    wdataSel = wdataQ;
    if (state == IDLE) begin
      addrSel  = bus.req_addr[ADDR_WIDTH+1:0];
      wenSel   = bus.req_wen;
      wdataSel = bus.req_wdata;
    end
  end

  assign idx     = addrSel[ADDR_WIDTH+1:2];
  assign oldWord = mem[idx];

  // Alignment rule: full words on word boundaries, halves on half boundaries.
  always_comb begin
    misaligned = 1'b0;
`ifdef ALIGN_CHECK_EN
    unique case (wenSel)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b1000: misaligned = 1'b0;
      4'b0011, 4'b1100: misaligned = addrSel[0];
      4'b1111:          misaligned = |addrSel[1:0];
      default:          misaligned = 1'b1;
    endcase
`endif
  end

  // Merge enabled byte lanes into the stored word.
  always_comb begin
    wenEff  = misaligned ? 4'b0000 : wenSel;
    newWord = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (wenEff[i]) newWord[8*i +: 8] = wdataSel[8*i +: 8];
    end
  end

  // Next-state, stall and completion decode.
  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    accept    = 1'b0;
    enterDone = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_en) begin
          stall  = 1'b1;
          accept = 1'b1;
          if (WC == 4'd0) begin
            stateNext = DONE;
            enterDone = 1'b1;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt <= 4'd1) begin
          stateNext = DONE;
          enterDone = 1'b1;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State, wait counter, request latch and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addrQ   <= '0;
      wenQ    <= 4'd0;
      wdataQ  <= 32'd0;
      rdataQ  <= 32'd0;
      rvalidQ <= 1'b0;
    end else begin
      state   <= stateNext;
      rvalidQ <= enterDone;
      if (accept) begin
        cnt    <= WC;
        addrQ  <= bus.req_addr[ADDR_WIDTH+1:0];
        wenQ   <= bus.req_wen;
        wdataQ <= bus.req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enterDone) rdataQ <= newWord;
    end
  end

  // RAM array is not reset; a write never lands while reset is held.
  always_ff @(posedge clk) begin
    if (enterDone && rst) mem[idx] <= newWord;
  end

`ifdef ALIGN_CHECK_EN
  logic errQ;

  // Error pulse lines up with the rvalid of the offending access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) errQ <= 1'b0;
    else      errQ <= enterDone & misaligned;
  end

  assign bus.err = errQ;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rdata  = rdataQ;
  assign bus.rvalid = rvalidQ;
  assign bus.stall  = stall;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: three instances (0, 1 and 3 wait states)
// checked against a word-array reference model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  logic        reqEn   [3];
  logic [3:0]  reqWen  [3];
  logic [31:0] reqAddr [3];
  logic [31:0] reqWdata[3];
  logic [31:0] rdataS  [3];
  logic        rvalidS [3];
  logic        stallS  [3];
  logic        errS    [3];

  for (genvar g = 0; g < 3; g++) begin : gd
    data_mem_responder_if bus ();
    assign bus.req_en    = reqEn[g];
    assign bus.req_wen   = reqWen[g];
    assign bus.req_addr  = reqAddr[g];
    assign bus.req_wdata = reqWdata[g];
    assign rdataS[g]  = bus.rdata;
    assign rvalidS[g] = bus.rvalid;
    assign stallS[g]  = bus.stall;
    assign errS[g]    = bus.err;
    data_mem_responder #(
      .ADDR_WIDTH (10),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] model [3][1024];
  bit          known [3][1024];
  logic [31:0] lastRdata;
  logic        lastErr;

  function automatic int wcOf(int d);
    return d == 0 ? 0 : (d == 1 ? 1 : 3);
  endfunction

  function automatic bit misal(logic [3:0] w, logic [31:0] a);
    bit bad = 1'b0;
`ifdef ALIGN_CHECK_EN
    if (!(w inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                    4'b1000, 4'b0011, 4'b1100, 4'b1111}))
      bad = 1'b1;
    else if (w == 4'b1111)
      bad = (a % 4) != 0;
    else if (w == 4'b0011 || w == 4'b1100)
      bad = (a % 2) != 0;
`endif
    return bad;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(int d, logic [31:0] a, logic [3:0] w,
                        logic [31:0] wd);
    int wi;
    bit bad;
    bit done;
    int cyc;
    int stallCnt;
    logic [31:0] exp;
    bit chk;
    wi  = int'((a / 4) % 1024);
    bad = misal(w, a);
    if (!bad) begin
      for (int i = 0; i < 4; i++)
        if (w[i]) model[d][wi][8*i +: 8] = wd[8*i +: 8];
      if (w == 4'b1111) known[d][wi] = 1'b1;
    end
    exp = model[d][wi];
    chk = known[d][wi];
    @(negedge clk);
    reqEn[d]    = 1'b1;
    reqWen[d]   = w;
    reqAddr[d]  = a;
    reqWdata[d] = wd;
    done = 1'b0;
    cyc = 0;
    stallCnt = 0;
    while (!done && cyc < 40) begin
      #1;
      if (rvalidS[d]) begin
        done = 1'b1;
        lastRdata = rdataS[d];
        lastErr = errS[d];
        check("done_stall", 32'(stallS[d]), 32'd0);
        if (chk) check("rdata", rdataS[d], exp);
        check("err", 32'(errS[d]), 32'(bad));
      end else begin
        if (stallS[d]) stallCnt++;
        cyc++;
        @(negedge clk);
      end
    end
    reqEn[d] = 1'b0;
    check("rvalid_seen", 32'(done), 32'd1);
    check("latency", 32'(cyc), 32'(wcOf(d) + 1));
    check("stall_cycles", 32'(stallCnt), 32'(wcOf(d) + 1));
  endtask

  initial begin
    logic [3:0] legal [8];
    legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
              4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int d = 0; d < 3; d++) begin
      reqEn[d] = 1'b0;
      reqWen[d] = 4'd0;
      reqAddr[d] = 32'd0;
      reqWdata[d] = 32'd0;
      for (int k = 0; k < 1024; k++) known[d][k] = 1'b0;
    end

    // reset then idle
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_rdata", rdataS[d], 32'd0);
      check("rst_rvalid", 32'(rvalidS[d]), 32'd0);
      check("rst_stall", 32'(stallS[d]), 32'd0);
      check("rst_err", 32'(errS[d]), 32'd0);
    end

    // word write then read, one wait state
    access(1, 32'h10, 4'b1111, 32'hDEADBEEF);
    access(1, 32'h10, 4'b0000, 32'h0);
    check("word_rd", lastRdata, 32'hDEADBEEF);

    // byte write into lane 2
    access(1, 32'h12, 4'b0100, 32'h55555555);
    access(1, 32'h10, 4'b0000, 32'h0);
    check("byte_rd", lastRdata, 32'hDE55BEEF);

    // back-to-back reads, zero wait states
    access(0, 32'h0, 4'b1111, 32'h0000AAAA);
    access(0, 32'h4, 4'b1111, 32'h0000BBBB);
    @(negedge clk);
    reqEn[0] = 1'b1;
    reqWen[0] = 4'b0000;
    reqAddr[0] = 32'h0;
    #1;
    check("b2b_stall0", 32'(stallS[0]), 32'd1);
    check("b2b_rv0", 32'(rvalidS[0]), 32'd0);
    @(negedge clk);
    #1;
    check("b2b_stall1", 32'(stallS[0]), 32'd0);
    check("b2b_rv1", 32'(rvalidS[0]), 32'd1);
    check("b2b_rd1", rdataS[0], 32'h0000AAAA);
    reqAddr[0] = 32'h4;
    @(negedge clk);
    #1;
    check("b2b_stall2", 32'(stallS[0]), 32'd1);
    check("b2b_rv2", 32'(rvalidS[0]), 32'd0);
    @(negedge clk);
    #1;
    check("b2b_stall3", 32'(stallS[0]), 32'd0);
    check("b2b_rv3", 32'(rvalidS[0]), 32'd1);
    check("b2b_rd3", rdataS[0], 32'h0000BBBB);
    reqEn[0] = 1'b0;

    // aliasing above the RAM range
    access(1, 32'h1000, 4'b1111, 32'h12345678);
    access(1, 32'h0, 4'b0000, 32'h0);
    check("alias_rd", lastRdata, 32'h12345678);

    // reset in the middle of a three-cycle wait
    access(2, 32'h20, 4'b1111, 32'hA5A5A5A5);
    @(negedge clk);
    reqEn[2] = 1'b1;
    reqWen[2] = 4'b1111;
    reqAddr[2] = 32'h20;
    reqWdata[2] = 32'h0BADF00D;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rv", 32'(rvalidS[2]), 32'd0);
    check("mid_stall_req", 32'(stallS[2]), 32'd1);
    reqEn[2] = 1'b0;
    #1;
    check("mid_stall_idle", 32'(stallS[2]), 32'd0);
    check("mid_rdata", rdataS[2], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_rv", 32'(rvalidS[2]), 32'd0);
    end
    access(2, 32'h20, 4'b0000, 32'h0);
    check("mid_keep", lastRdata, 32'hA5A5A5A5);

    // misaligned full-word write
    access(1, 32'h20, 4'b1111, 32'h01020304);
    access(1, 32'h21, 4'b1111, 32'hFFFFFFFF);
`ifdef ALIGN_CHECK_EN
    check("align_err", 32'(lastErr), 32'd1);
    access(1, 32'h20, 4'b0000, 32'h0);
    check("align_keep", lastRdata, 32'h01020304);
`else
    check("align_noerr", 32'(lastErr), 32'd0);
`endif

    // randomized traffic against the model
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 16; k++)
        access(d, (32'($urandom_range(0, 15)) << 12) | 32'(k * 4),
               4'b1111, $urandom);
      for (int n = 0; n < 40; n++) begin
        logic [31:0] a;
        logic [3:0] w;
        a = (32'($urandom_range(0, 15)) << 12)
            | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0)
          w = legal[$urandom_range(0, 7)];
        else
          w = 4'($urandom);
        access(d, a, w, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
